// File: rtl/dual_port_data_mem.sv
// Dual-port (1R/1W) data memory with registered read, valid strobe,
// selectable read-during-write policy and a post-reset hardware clear sweep.
module dual_port_data_mem #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned RDW_MODE    = 0,
   parameter int unsigned RESET_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              req_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              req_drop_q, req_drop_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      busy_d     = busy_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      req_drop_d = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = wr_addr;
      mem_wdata  = wr_data;

      case (state_q)
         CLEAR: begin
            mem_we     = 1'b1;
            mem_waddr  = clr_cnt_q;
            mem_wdata  = '0;
            clr_cnt_d  = clr_cnt_q + 1'b1;
            req_drop_d = wr_en | rd_en;
            // Terminal address detected explicitly so the counter wrap is irrelevant.
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         READY: begin
            mem_we = wr_en;
            if (rd_en) begin
               rd_valid_d = 1'b1;
               if (RDW_MODE == 0 && wr_en && wr_addr == rd_addr)
                  rd_data_d = wr_data;
               else
                  rd_data_d = mem_q[rd_addr];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (RESET_CLEAR != 0) ? CLEAR : READY;
         clr_cnt_q  <= '0;
         busy_q     <= (RESET_CLEAR != 0);
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         req_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         busy_q     <= busy_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         req_drop_q <= req_drop_d;
         if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign req_drop = req_drop_q;

endmodule
